// File: rtl/sha256_compress_if.sv
// Handshake and data bundle between the message scheduler / chaining logic and
// the SHA-256 compression engine.
interface sha256_compress_if;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_ready;
  logic [5:0]   w_index;
  logic         busy;
  logic [255:0] digest_out;
  logic         digest_valid;

  modport master (
    output start, h_in, w_in, w_valid,
    input  w_ready, w_index, busy, digest_out, digest_valid
  );

  modport slave (
    input  start, h_in, w_in, w_valid,
    output w_ready, w_index, busy, digest_out, digest_valid
  );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: one round per accepted schedule word, then a
// chaining-value add that publishes the intermediate digest for one block.
module sha256_compress #(
  parameter int ROUNDS = 64
) (
  input  logic clk,
  input  logic reset,
  sha256_compress_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Element 0 is the most significant word: a / H0 live in [255:224].
  state_e             state_q, state_d;
  logic [5:0]         t_q, t_d;
  logic [0:7][31:0]   work_q, work_d;
  logic [0:7][31:0]   hreg_q, hreg_d;
  logic [0:7][31:0]   digest_q, digest_d;
  logic               dv_q, dv_d;
  logic [31:0]        t1_s, t2_s;

  // Round datapath: T1/T2 for the current working variables and word.
  always_comb begin
    t1_s = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
         + K[t_q] + bus.w_in;
    t2_s = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
  end

  // Next-state logic; a start is ignored while the previous digest pulse is out.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    work_d   = work_q;
    hreg_d   = hreg_q;
    digest_d = digest_q;
    dv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !dv_q) begin
          hreg_d  = bus.h_in;
          work_d  = bus.h_in;
          t_d     = 6'd0;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        if (bus.w_valid) begin
          work_d = {t1_s + t2_s, work_q[0], work_q[1], work_q[2],
                    work_q[3] + t1_s, work_q[4], work_q[5], work_q[6]};
          t_d    = t_q + 6'd1;
          if (t_q == LAST_T) begin
            state_d = FINAL;
          end else begin
            state_d = ROUND;
          end
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          digest_d[i] = hreg_q[i] + work_q[i];
        end
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      t_q      <= 6'd0;
      work_q   <= '0;
      hreg_q   <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      work_q   <= work_d;
      hreg_q   <= hreg_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
    end
  end

  // busy stays high through the digest_valid cycle that follows FINAL.
  assign bus.w_ready      = (state_q == ROUND);
  assign bus.w_index      = (state_q == ROUND) ? t_q : 6'd0;
  assign bus.busy         = (state_q != IDLE) || dv_q;
  assign bus.digest_out   = digest_q;
  assign bus.digest_valid = dv_q;

endmodule
